// File: rtl/lc3_pkg.sv
// Shared LC-3 control definitions: ISDU state encoding, opcodes and the
// datapath mux/ALU select encodings driven by the control unit.
package lc3_pkg;

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32,
        S01, S05, S09, S06, S07,
        S25, S27, S23, S16, S04,
        S21, S20, S12, S00, S22,
        PAUSE1, PAUSE2
    } isdu_state_e;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_PC1   = 2'd0;
    localparam logic [1:0] PCMUX_BUS   = 2'd1;
    localparam logic [1:0] PCMUX_ADDER = 2'd2;

    localparam logic [1:0] ADDR2_ZERO  = 2'd0;
    localparam logic [1:0] ADDR2_OFF6  = 2'd1;
    localparam logic [1:0] ADDR2_OFF9  = 2'd2;
    localparam logic [1:0] ADDR2_OFF11 = 2'd3;

    localparam logic [1:0] ALUK_ADD  = 2'd0;
    localparam logic [1:0] ALUK_AND  = 2'd1;
    localparam logic [1:0] ALUK_NOT  = 2'd2;
    localparam logic [1:0] ALUK_PASS = 2'd3;

    // First execute state for each opcode; unimplemented opcodes refetch.
    function automatic isdu_state_e decode_opcode(input logic [3:0] op);
        case (op)
            OP_ADD:   return S01;
            OP_AND:   return S05;
            OP_NOT:   return S09;
            OP_BR:    return S00;
            OP_JMP:   return S12;
            OP_JSR:   return S04;
            OP_LDR:   return S06;
            OP_STR:   return S07;
            OP_PAUSE: return PAUSE1;
            default:  return S18;
        endcase
    endfunction

endpackage

// File: rtl/isdu_control.sv
// LC-3 instruction sequencing and decode unit: Moore FSM producing the
// datapath load enables, bus gates, mux selects and memory strobes.
module isdu_control
    import lc3_pkg::*;
(
    input  logic        Clk,
    input  logic        reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    input  logic        mem_rdy,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_LED,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output isdu_state_e state_o
);

    isdu_state_e state_q, state_d;

    // Register-field bits are consumed by the datapath, not by sequencing.
    logic unused_ir;
    assign unused_ir = ^{IR[10:6], IR[4:0]};

    assign state_o = state_q;

    always_ff @(posedge Clk) begin
        if (reset) state_q <= HALTED;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_PC1;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_ZERO;
        ALUK       = ALUK_ADD;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;

        case (state_q)
            HALTED: if (Run) state_d = S18;
            S18: begin
                GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PCMUX_PC1;
                state_d = S33;
            end
            S33: begin
                Mem_OE = 1'b1; LD_MDR = 1'b1;
                if (mem_rdy) state_d = S35;
            end
            S35: begin
                GateMDR = 1'b1; LD_IR = 1'b1;
                state_d = S32;
            end
            S32: begin
                LD_BEN  = 1'b1;
                state_d = decode_opcode(IR[15:12]);
            end
            S01, S05: begin
                SR1MUX = 1'b1; SR2MUX = IR[5]; GateALU = 1'b1;
                ALUK   = (state_q == S01) ? ALUK_ADD : ALUK_AND;
                DRMUX  = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                state_d = S18;
            end
            S09: begin
                SR1MUX = 1'b1; ALUK = ALUK_NOT; GateALU = 1'b1;
                DRMUX  = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                state_d = S18;
            end
            S06, S07: begin
                ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF6; SR1MUX = 1'b1;
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
                state_d = (state_q == S06) ? S25 : S23;
            end
            S25: begin
                Mem_OE = 1'b1; LD_MDR = 1'b1;
                if (mem_rdy) state_d = S27;
            end
            S27: begin
                GateMDR = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                state_d = S18;
            end
            S23: begin
                SR1MUX = 1'b0; ALUK = ALUK_PASS; GateALU = 1'b1; LD_MDR = 1'b1;
                state_d = S16;
            end
            S16: begin
                Mem_WE = 1'b1;
                if (mem_rdy) state_d = S18;
            end
            S04: begin
                GatePC = 1'b1; DRMUX = 1'b0; LD_REG = 1'b1;
                state_d = IR[11] ? S21 : S20;
            end
            S21: begin
                ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_OFF11; PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
                state_d = S18;
            end
            S20, S12: begin
                SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_ZERO;
                PCMUX  = PCMUX_ADDER; LD_PC = 1'b1;
                state_d = S18;
            end
            S00: state_d = BEN ? S22 : S18;
            S22: begin
                ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_OFF9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
                state_d = S18;
            end
            PAUSE1: begin
                LD_LED = 1'b1;
                if (Continue) state_d = PAUSE2;
            end
            PAUSE2: if (!Continue) state_d = S18;
            default: state_d = HALTED;
        endcase
    end

endmodule

// File: tb/tb_isdu_control.sv
// Self-checking bench for isdu_control: each instruction is expanded into the
// cycle-by-cycle control words it should produce, then replayed against the DUT.
module tb_isdu_control;
    import lc3_pkg::*;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic mem_oe, mem_we;
    } ctl_t;

    typedef struct {
        isdu_state_e st;
        ctl_t        ctl;
        logic        mem_rdy;
        logic        cont;
        logic        run;
    } step_t;

    logic        Clk = 1'b0;
    logic        reset, Run, Continue, BEN, mem_rdy;
    logic [15:0] IR;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;
    isdu_state_e state_o;
    ctl_t        obs;

    step_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    logic  halted   = 1'b1;

    always #5 Clk = ~Clk;

    isdu_control dut (
        .Clk(Clk), .reset(reset), .Run(Run), .Continue(Continue), .IR(IR),
        .BEN(BEN), .mem_rdy(mem_rdy),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .state_o(state_o)
    );

    assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
                  SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input isdu_state_e st, input ctl_t c, input logic rdy, input logic cont);
        step_t s;
        s.st = st; s.ctl = c; s.mem_rdy = rdy; s.cont = cont; s.run = rbit();
        exp_q.push_back(s);
    endtask

    task automatic push_halt(input logic run);
        step_t s;
        s.st = HALTED; s.ctl = '0; s.mem_rdy = rbit(); s.cont = rbit(); s.run = run;
        exp_q.push_back(s);
    endtask

    // A memory access holds its word for w not-ready cycles plus the ready one.
    task automatic push_mem(input isdu_state_e st, input ctl_t c, input int w);
        for (int i = 0; i < w; i++) push(st, c, 1'b0, rbit());
        push(st, c, 1'b1, rbit());
    endtask

    task automatic plan_fetch(input int w);
        ctl_t c;
        c = '0; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; c.pcmux = 2'd0;
        push(S18, c, rbit(), rbit());
        c = '0; c.mem_oe = 1; c.ld_mdr = 1;
        push_mem(S33, c, w);
        c = '0; c.gate_mdr = 1; c.ld_ir = 1;
        push(S35, c, rbit(), rbit());
        c = '0; c.ld_ben = 1;
        push(S32, c, rbit(), rbit());
    endtask

    task automatic plan_exec(input logic [15:0] ir, input logic ben, input int w);
        ctl_t c;
        int   k;
        c = '0;
        case (ir[15:12])
            4'b0001, 4'b0101: begin
                c.sr1mux = 1; c.sr2mux = ir[5]; c.gate_alu = 1;
                c.aluk = (ir[15:12] == 4'b0001) ? 2'd0 : 2'd1;
                c.drmux = 1; c.ld_reg = 1; c.ld_cc = 1;
                push((ir[15:12] == 4'b0001) ? S01 : S05, c, rbit(), rbit());
            end
            4'b1001: begin
                c.sr1mux = 1; c.aluk = 2'd2; c.gate_alu = 1;
                c.drmux = 1; c.ld_reg = 1; c.ld_cc = 1;
                push(S09, c, rbit(), rbit());
            end
            4'b0110, 4'b0111: begin
                c.addr1mux = 1; c.addr2mux = 2'd1; c.sr1mux = 1; c.gate_marmux = 1; c.ld_mar = 1;
                if (ir[15:12] == 4'b0110) begin
                    push(S06, c, rbit(), rbit());
                    c = '0; c.mem_oe = 1; c.ld_mdr = 1;
                    push_mem(S25, c, w);
                    c = '0; c.gate_mdr = 1; c.drmux = 1; c.ld_reg = 1; c.ld_cc = 1;
                    push(S27, c, rbit(), rbit());
                end else begin
                    push(S07, c, rbit(), rbit());
                    c = '0; c.aluk = 2'd3; c.gate_alu = 1; c.ld_mdr = 1;
                    push(S23, c, rbit(), rbit());
                    c = '0; c.mem_we = 1;
                    push_mem(S16, c, w);
                end
            end
            4'b0100: begin
                c.gate_pc = 1; c.ld_reg = 1;
                push(S04, c, rbit(), rbit());
                c = '0; c.pcmux = 2'd2; c.ld_pc = 1;
                if (ir[11]) begin
                    c.addr2mux = 2'd3;
                    push(S21, c, rbit(), rbit());
                end else begin
                    c.sr1mux = 1; c.addr1mux = 1;
                    push(S20, c, rbit(), rbit());
                end
            end
            4'b1100: begin
                c.sr1mux = 1; c.addr1mux = 1; c.pcmux = 2'd2; c.ld_pc = 1;
                push(S12, c, rbit(), rbit());
            end
            4'b0000: begin
                push(S00, c, rbit(), rbit());
                if (ben) begin
                    c.addr2mux = 2'd2; c.pcmux = 2'd2; c.ld_pc = 1;
                    push(S22, c, rbit(), rbit());
                end
            end
            4'b1101: begin
                c.ld_led = 1;
                k = $urandom_range(0, 3);
                for (int i = 0; i < k; i++) push(PAUSE1, c, rbit(), 1'b0);
                push(PAUSE1, c, rbit(), 1'b1);
                c = '0;
                k = $urandom_range(0, 3);
                for (int i = 0; i < k; i++) push(PAUSE2, c, rbit(), 1'b1);
                push(PAUSE2, c, rbit(), 1'b0);
            end
            default: ;
        endcase
    endtask

    // Replays the expected queue; reset is pulsed on step rst_idx, after which
    // only a HALTED cycle is expected.
    task automatic run_plan(input logic [15:0] ir, input logic ben, input int rst_idx);
        step_t s;
        int    idx = 0;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            @(negedge Clk);
            check($sformatf("state#%0d", idx), 32'(state_o), 32'(s.st));
            check($sformatf("ctl@%s", s.st.name()), 32'(obs), 32'(s.ctl));
            IR = ir; BEN = ben; mem_rdy = s.mem_rdy; Continue = s.cont; Run = s.run;
            reset = 1'b0;
            halted = (s.st == HALTED) && !s.run;
            if (idx == rst_idx) begin
                reset = 1'b1;
                exp_q.delete();
                push_halt(1'b0);
            end
            idx++;
        end
    endtask

    // rst_mode: 0 none, 1 during the first S16 cycle, 2 at a random cycle sometimes.
    task automatic do_instr(input logic [15:0] ir, input logic ben, input int wf,
                            input int w, input int rst_mode);
        int rst_idx = -1;
        if (halted) begin
            repeat ($urandom_range(1, 3)) push_halt(1'b0);
            push_halt(1'b1);
        end
        plan_fetch(wf);
        plan_exec(ir, ben, w);
        if (rst_mode == 1) begin
            for (int i = 0; i < exp_q.size(); i++)
                if (exp_q[i].st == S16 && rst_idx < 0) rst_idx = i;
        end else if (rst_mode == 2 && $urandom_range(0, 9) == 0) begin
            rst_idx = $urandom_range(0, exp_q.size() - 1);
        end
        run_plan(ir, ben, rst_idx);
    endtask

    initial begin
        logic [15:0] ir;
        reset = 1'b1; Run = 1'b0; Continue = 1'b0; BEN = 1'b0; mem_rdy = 1'b1; IR = 16'h0000;
        repeat (2) @(negedge Clk);
        check("reset_state", 32'(state_o), 32'(HALTED));
        check("reset_ctl", 32'(obs), 32'h0);
        Run = 1'b1;
        @(negedge Clk);
        check("reset_hold", 32'(state_o), 32'(HALTED));
        reset = 1'b0; Run = 1'b0;
        halted = 1'b1;

        do_instr(16'h1042, 1'b0, 0, 0, 0);
        do_instr(16'h1062, 1'b1, 1, 0, 0);
        do_instr(16'h6042, 1'b0, 0, 3, 0);
        do_instr(16'h0E05, 1'b1, 0, 0, 0);
        do_instr(16'h0E05, 1'b0, 2, 0, 0);
        do_instr(16'hD000, 1'b0, 0, 0, 0);
        do_instr(16'h4800, 1'b0, 0, 0, 0);
        do_instr(16'h4000, 1'b0, 0, 0, 0);
        do_instr(16'hC1C0, 1'b0, 0, 0, 0);
        do_instr(16'h927F, 1'b0, 0, 0, 0);
        do_instr(16'hF025, 1'b0, 0, 0, 0);
        do_instr(16'h7042, 1'b0, 0, 2, 1);
        check("halt_after_s16_reset", 32'(halted), 32'h1);

        for (int n = 0; n < 300; n++) begin
            ir = 16'($urandom);
            do_instr(ir, rbit(), $urandom_range(0, 3), $urandom_range(0, 3), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/isdu_control.md
ISDU_CONTROL -- requirements
Module: isdu_control

Interface
REQ-001 Clk  in  1  system clock; every state register updates on the rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on the rising edge of Clk.
REQ-003 Run  in  1  start execution from HALTED.
REQ-004 Continue  in  1  resume from a PAUSE instruction.
REQ-005 IR  in  16  current instruction; opcode is IR[15:12], IR[5] is the immediate flag, IR[11] is the JSR/JSRR flag.
REQ-006 BEN  in  1  branch-enable flag from the BEN register.
REQ-007 mem_rdy  in  1  memory read/write completion strobe.
REQ-008 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load enables.
REQ-009 GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one is high per cycle.
REQ-010 PCMUX  out  2  next-PC select: 0 = PC+1, 1 = bus, 2 = adder.
REQ-011 DRMUX  out  1  destination select: 1 = IR[11:9], 0 = R7.
REQ-012 SR1MUX  out  1  source-1 select: 0 = IR[11:9], 1 = IR[8:6].
REQ-013 SR2MUX  out  1  ALU B select: 0 = SR2 register, 1 = sext(IR[4:0]).
REQ-014 ADDR1MUX  out  1  0 = PC, 1 = SR1_OUT.
REQ-015 ADDR2MUX  out  2  0 = zero, 1 = off6, 2 = off9, 3 = off11.
REQ-016 ALUK  out  2  0 = ADD, 1 = AND, 2 = NOT A, 3 = PASS A.
REQ-017 Mem_OE, Mem_WE  out  1 each  memory read and write strobes, active-high.

Function
REQ-018 The block SHALL be a Moore FSM; all outputs are a pure function of the current state, and every output not listed for a state is 0.
REQ-019 HALTED: all outputs are 0; the FSM moves to S18 when Run=1.
REQ-020 S18: GatePC, LD_MAR, LD_PC, PCMUX=0; the FSM moves to S33.
REQ-021 S33: Mem_OE, LD_MDR; the FSM holds while mem_rdy=0 and moves to S35 on mem_rdy=1.
REQ-022 S35: GateMDR, LD_IR; the FSM moves to S32.
REQ-023 S32: LD_BEN; the next state is decoded from the opcode:
  - 0001 -> S01
  - 0101 -> S05
  - 1001 -> S09
  - 0000 -> S00
  - 1100 -> S12
  - 0100 -> S04
  - 0110 -> S06
  - 0111 -> S07
  - 1101 -> PAUSE1
  - all other opcodes -> S18
REQ-024 S01/S05: SR1MUX=1, SR2MUX=IR[5], ALUK=0/1 respectively, GateALU, DRMUX=1, LD_REG, LD_CC; the FSM moves to S18.
REQ-025 S09: SR1MUX=1, ALUK=2, GateALU, DRMUX=1, LD_REG, LD_CC; the FSM moves to S18.
REQ-026 S06/S07: ADDR1MUX=1, ADDR2MUX=1, SR1MUX=1, GateMARMUX, LD_MAR; S06 moves to S25 and S07 moves to S23.
REQ-027 S25: Mem_OE, LD_MDR; the FSM waits on mem_rdy and then moves to S27. S27: GateMDR, DRMUX=1, LD_REG, LD_CC; the FSM moves to S18.
REQ-028 S23: SR1MUX=0, ALUK=3, GateALU, LD_MDR; the FSM moves to S16.
REQ-029 S16: Mem_WE; the FSM waits on mem_rdy and then moves to S18.
REQ-030 S04: GatePC, DRMUX=0, LD_REG; the next state is S21 if IR[11]=1, else S20.
REQ-031 S21: ADDR1MUX=0, ADDR2MUX=3, PCMUX=2, LD_PC; the FSM moves to S18.
REQ-032 S20/S12: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=0, PCMUX=2, LD_PC; the FSM moves to S18.
REQ-033 S00: no outputs asserted; the next state is S22 if BEN=1, else S18.
REQ-034 S22: ADDR1MUX=0, ADDR2MUX=2, PCMUX=2, LD_PC; the FSM moves to S18.
REQ-035 PAUSE1: LD_LED; the FSM holds while Continue=0 and moves to PAUSE2 on Continue=1.
REQ-036 PAUSE2: the FSM holds while Continue=1 and moves to S18 on Continue=0.
REQ-037 Minimum latency from S18 back to S18 is 5 cycles for ADD with mem_rdy tied high, with one extra cycle per cycle that mem_rdy is low.
REQ-038 Run is ignored outside HALTED.

Reset
REQ-039 reset=1 SHALL force the state to HALTED on the next edge and override every other transition, including mid-instruction and during memory waits.
REQ-040 While the state is HALTED, all outputs are 0, including Mem_WE, so no memory write is in progress.

Structure
REQ-041 The state enum, opcode constants, and the PCMUX/ADDR2MUX/ALUK encodings SHALL live in the shared package lc3_pkg.
REQ-042 The block is implemented as a single module with no sub-modules: one sequential always_ff for state and one always_comb for next-state and outputs.

Verification
REQ-043 Scenario: reset, then Run=1 with mem_rdy=1 -> state sequence HALTED, S18, S33, S35, S32.
REQ-044 Scenario: IR=16'h1042 (ADD) -> S01 asserts LD_REG=1, DRMUX=1, SR1MUX=1, SR2MUX=0, ALUK=0 for exactly 1 cycle.
REQ-045 Scenario: IR=16'h6042 (LDR) with mem_rdy low for 3 cycles in S25 -> S25 persists 4 cycles, then S27 asserts GateMDR and LD_REG.
REQ-046 Scenario: IR=16'h0E05 (BR) -> with BEN=1, S22 asserts PCMUX=2 and ADDR2MUX=2; with BEN=0, S00 is followed by S18.
REQ-047 Scenario: IR=16'hD000 (PAUSE) -> LD_LED=1 until Continue rises, then PAUSE2 until Continue falls, then S18.
REQ-048 Scenario: reset asserted during S16 -> the next state is HALTED and Mem_WE=0.
